oldland_exception_ctrl: RTL and testbench
=========================================

# oldland_exception_ctrl

Sequencer for exception and interrupt entry on the Oldland core. It latches pending events, prioritises them, stalls and drains the pipeline, and strobes the execute stage's PSR/fault-address save controls. It then redirects fetch to the selected vector or TLB-miss handler. It sits between the fetch/memory stages, which raise events, and the execute stage, which owns the control registers.

## Interface
- `DRAIN_TIMEOUT`, default 15: maximum number of DRAIN cycles spent waiting for `pipe_idle`.
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous and active-low.
- `data_abort_req` in 1: data abort, one-cycle pulse.
- `dtlb_miss_req` in 1: DTLB miss, pulse.
- `itlb_miss_req` in 1: ITLB miss, pulse.
- `illegal_instr_req` in 1: undefined opcode, pulse.
- `irq_req` in 1: external interrupt, level.
- `irqs_enabled` in 1: PSR interrupt enable, from the execute stage.
- `irq_resume_pc` in 32: PC to resume after the interrupt.
- `pipe_idle` in 1: no loads or stores in flight.
- `vector_base` in 26: CR0[31:6].
- `dtlb_miss_handler` in 30: CR5[31:2].
- `itlb_miss_handler` in 30: CR6[31:2].
- `stall` out 1: freezes fetch and decode.
- `pipeline_flush` out 1: kills instructions younger than the faulting one.
- `exception_start` out 1: one-cycle pulse.
- `irq_start` out 1: one-cycle pulse.
- `exception_disable_irqs` out 1: one-cycle pulse.
- `exception_disable_mmu` out 1: one-cycle pulse.
- `exception_fault_address` out 32: address saved into CR3 on `irq_start`.
- `redirect_valid` out 1: fetch redirect strobe, one cycle.
- `redirect_pc` out 32: fetch redirect target.
- `drain_timeout` out 1: sticky flag; cleared only by reset.

## Operation
- **`pending[4:0]` register.**
  - Each pulse sets its bit; the bit clears only when that event is entered.
  - `irq_req` is sampled only as `irq_req && irqs_enabled`, and only in IDLE. It is never latched.
- **Priority, high to low:** data abort > DTLB miss > ITLB miss > illegal instruction > IRQ.
- **FSM states:** IDLE, DRAIN, ENTER, REDIRECT.
  - **IDLE:** if any event is pending or qualified, go to DRAIN.
  - **DRAIN:**
    - `stall` = 1; `pipeline_flush` = 1 on the first DRAIN cycle only.
    - Count cycles. Go to ENTER when `pipe_idle` = 1, or when the count reaches `DRAIN_TIMEOUT` (this also sets `drain_timeout`).
    - The winner is selected at the DRAIN→ENTER transition. A higher-priority event arriving during DRAIN displaces a lower one, which stays pending.
  - **ENTER:** `stall` = 1; strobes per the winner:
    - Data abort, illegal instruction: `exception_start`, `exception_disable_irqs`.
    - DTLB/ITLB miss: `exception_start`, `exception_disable_mmu`.
    - IRQ: `irq_start`, `exception_disable_irqs`; `exception_fault_address` = `irq_resume_pc` captured at IDLE→DRAIN. It is held otherwise and reads 0 after reset.
  - **REDIRECT:** `redirect_valid` = 1, `stall` = 1; next state IDLE. `redirect_pc`:
    - illegal: `{vector_base, 6'h04}`
    - IRQ: `{vector_base, 6'h0c}`
    - data abort: `{vector_base, 6'h14}`
    - DTLB miss: `{dtlb_miss_handler, 2'b00}`
    - ITLB miss: `{itlb_miss_handler, 2'b00}`
- **Drain counter:** width `$clog2(DRAIN_TIMEOUT+1)`; saturates; cleared on entry to DRAIN.
- **Back-to-back events:** an event remaining pending after REDIRECT is serviced starting from IDLE on the next cycle. IDLE always lasts at least one cycle.
- **Reset:** every output is 0, `pending` = 0, state = IDLE. Reset applied in any state aborts the sequence with no strobes issued.

## Timing
- **Event → redirect latency:** request at cycle N (pulse inputs are registered into `pending`, so the request first appears at IDLE in N+1):
  - N+1: IDLE.
  - N+2: DRAIN, minimum one cycle.
  - N+3: ENTER.
  - N+4: REDIRECT.
  - Minimum latency is therefore 4 cycles, plus extra DRAIN cycles while `pipe_idle` = 0.
- **Strobes and redirect:** all strobes are high for exactly the ENTER cycle. `redirect_valid` is high for exactly the REDIRECT cycle.
- **Stall:** `stall` is high from DRAIN through REDIRECT inclusive and falls in the first IDLE cycle.
- **Stale events:** a request pulse coincident with its own clear in ENTER re-sets the bit, giving a second entry. The source must not re-pulse for the same fault.

## Configuration
- `OLDLAND_TLB_MISS_EN`
  - Defined: DTLB/ITLB misses are handled as above.
  - Undefined: `dtlb_miss_req`/`itlb_miss_req` are ignored, their pending bits are constant 0, and `exception_disable_mmu` is constant 0. The handler inputs stay as ports and are unused.

## Test plan
- Illegal-instruction pulse with `vector_base` = 0x100, `pipe_idle` = 1 → 4 cycles later: `redirect_pc` = 0x4004. `exception_start` and `exception_disable_irqs` are high in the preceding cycle.
- `irq_req` = 1, `irqs_enabled` = 1, `irq_resume_pc` = 0x1230 → `irq_start` pulses, `exception_fault_address` = 0x1230, `redirect_pc` = `{vector_base, 6'h0c}`. The same request with `irqs_enabled` = 0 → no activity.
- Data abort and DTLB miss in the same cycle, `dtlb_miss_handler` = 0x400 → first redirect to `{vector_base, 6'h14}`. The second sequence redirects to 0x1000 with `exception_disable_mmu` high.
- `pipe_idle` held 0, `DRAIN_TIMEOUT` = 15 → ENTER after 15 DRAIN cycles and `drain_timeout` = 1. It stays 1 until reset.
- Reset asserted in DRAIN → all outputs 0 next cycle, no ENTER strobes, `pending` cleared.
- With `OLDLAND_TLB_MISS_EN` undefined, an ITLB-miss pulse → `stall` stays 0 and no redirect.

Source files
------------

// File: rtl/oldland_exception_ctrl.sv
// oldland_exception_ctrl
//
// Sequences exception and interrupt entry for the Oldland core. Fault
// pulses from fetch/memory are latched into a pending set. A qualified
// external interrupt starts a sequence but is never latched. The
// sequencer stalls and drains the pipeline, then picks the
// highest-priority event. It strobes the execute stage's save controls
// for one cycle and then redirects fetch to the matching vector or
// TLB-miss handler.
//
// Priority (high to low): data abort, DTLB miss, ITLB miss,
// illegal instruction, IRQ.
//
// Build option:
//   OLDLAND_TLB_MISS_EN - when defined, DTLB/ITLB misses are serviced.
//                         When undefined, the miss requests are
//                         ignored and exception_disable_mmu is tied
//                         low. The handler address ports remain.
//
// Ports:
//   clk, rst                   core clock, synchronous active-low reset
//   data_abort_req             data abort pulse
//   dtlb_miss_req              DTLB miss pulse
//   itlb_miss_req              ITLB miss pulse
//   illegal_instr_req          undefined opcode pulse
//   irq_req                    external interrupt level
//   irqs_enabled               PSR interrupt enable
//   irq_resume_pc              PC to resume after an interrupt
//   pipe_idle                  no loads/stores in flight
//   vector_base                CR0[31:6]
//   dtlb_miss_handler          CR5[31:2]
//   itlb_miss_handler          CR6[31:2]
//   stall                      freeze fetch/decode (DRAIN..REDIRECT)
//   pipeline_flush             kill younger instructions (first DRAIN cycle)
//   exception_start            ENTER strobe for faults
//   irq_start                  ENTER strobe for interrupts
//   exception_disable_irqs     ENTER strobe, clear PSR interrupt enable
//   exception_disable_mmu      ENTER strobe, disable MMU for TLB misses
//   exception_fault_address    value saved into CR3 on irq_start
//   redirect_valid             fetch redirect strobe (REDIRECT cycle)
//   redirect_pc                fetch redirect target
//   drain_timeout              sticky: a drain gave up waiting for pipe_idle
//
// State table:
//   state      | meaning
//   IDLE       | waiting for a pending or qualified event
//   DRAIN      | stall, flush on first cycle, wait for pipe_idle or timeout
//   ENTER      | strobe save/disable controls for the selected event
//   REDIRECT   | drive the fetch redirect, then return to IDLE

module oldland_exception_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_abort_req,
  input  logic        dtlb_miss_req,
  input  logic        itlb_miss_req,
  input  logic        illegal_instr_req,
  input  logic        irq_req,
  input  logic        irqs_enabled,
  input  logic [31:0] irq_resume_pc,
  input  logic        pipe_idle,
  input  logic [25:0] vector_base,
  input  logic [29:0] dtlb_miss_handler,
  input  logic [29:0] itlb_miss_handler,
  output logic        stall,
  output logic        pipeline_flush,
  output logic        exception_start,
  output logic        irq_start,
  output logic        exception_disable_irqs,
  output logic        exception_disable_mmu,
  output logic [31:0] exception_fault_address,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);

  localparam int unsigned CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW:0] TIMEOUT_VAL = (CW+1)'(DRAIN_TIMEOUT);

  // Bit positions in pending/winner; lower index is higher priority.
  localparam int EV_ABORT   = 0;
  localparam int EV_DTLB    = 1;
  localparam int EV_ITLB    = 2;
  localparam int EV_ILLEGAL = 3;
  localparam int EV_IRQ     = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_ENTER    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t state, state_next;

  // pending[3:0] hold latched fault pulses. pending[4] records that a
  // qualified IRQ started the current sequence. It lives only until the
  // winner is chosen; a level IRQ that loses is simply re-sampled later.
  logic [4:0]    pending;
  logic [4:0]    winner;
  logic [4:0]    winner_sel;
  logic [3:0]    req_set;
  logic [3:0]    pend_clr;
  logic [CW-1:0] drain_cnt;
  logic [CW:0]   drain_cnt_inc;
  logic [31:0]   irq_pc;
  logic          irq_qual;
  logic          timeout_hit;
  logic          idle_to_drain;
  logic          drain_to_enter;
  logic          mmu_strobe;

`ifdef OLDLAND_TLB_MISS_EN
  assign req_set = {illegal_instr_req, itlb_miss_req, dtlb_miss_req, data_abort_req};
  assign exception_disable_mmu = mmu_strobe;
`else
  assign req_set = {illegal_instr_req, 1'b0, 1'b0, data_abort_req};
  assign exception_disable_mmu = 1'b0;
  logic unused_tlb;
  assign unused_tlb = ^{dtlb_miss_req, itlb_miss_req, mmu_strobe};
`endif

  assign irq_qual = irq_req & irqs_enabled;

  // Isolate the lowest set bit: the highest-priority candidate.
  assign winner_sel = pending & (~pending + 5'd1);

  // drain_cnt holds the DRAIN cycles already spent, so the incremented
  // value is the count including the current cycle.
  assign drain_cnt_inc = {1'b0, drain_cnt} + (CW+1)'(1);
  assign timeout_hit   = (drain_cnt_inc >= TIMEOUT_VAL);

  assign idle_to_drain  = (state == S_IDLE)  && (state_next == S_DRAIN);
  assign drain_to_enter = (state == S_DRAIN) && (state_next == S_ENTER);

  // The winner's bit clears during ENTER. A pulse arriving in the same
  // cycle re-arms it.
  assign pend_clr = (state == S_ENTER) ? winner[3:0] : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                   <= S_IDLE;
      pending                 <= 5'b00000;
      winner                  <= 5'b00000;
      drain_cnt               <= '0;
      irq_pc                  <= 32'h0;
      exception_fault_address <= 32'h0;
      drain_timeout           <= 1'b0;
    end else begin
      state        <= state_next;
      pending[3:0] <= (pending[3:0] & ~pend_clr) | req_set;

      if (idle_to_drain) begin
        pending[EV_IRQ] <= irq_qual;
        irq_pc          <= irq_resume_pc;
        drain_cnt       <= '0;
      end else if (state == S_DRAIN && ({1'b0, drain_cnt} < TIMEOUT_VAL)) begin
        drain_cnt <= drain_cnt_inc[CW-1:0];
      end

      if (drain_to_enter) begin
        pending[EV_IRQ] <= 1'b0;
        winner          <= winner_sel;
        if (winner_sel[EV_IRQ]) begin
          exception_fault_address <= irq_pc;
        end
        // Leaving DRAIN without pipe_idle means the timeout forced it.
        if (!pipe_idle) begin
          drain_timeout <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next             = state;
    stall                  = 1'b0;
    pipeline_flush         = 1'b0;
    exception_start        = 1'b0;
    irq_start              = 1'b0;
    exception_disable_irqs = 1'b0;
    mmu_strobe             = 1'b0;
    redirect_valid         = 1'b0;
    redirect_pc            = 32'h0;

    unique case (state)
      S_IDLE: begin
        if ((|pending[3:0]) || irq_qual) begin
          state_next = S_DRAIN;
        end
      end

      S_DRAIN: begin
        stall          = 1'b1;
        pipeline_flush = (drain_cnt == '0);
        if (pipe_idle || timeout_hit) begin
          state_next = S_ENTER;
        end
      end

      S_ENTER: begin
        stall = 1'b1;
        if (winner[EV_ABORT] || winner[EV_ILLEGAL]) begin
          exception_start        = 1'b1;
          exception_disable_irqs = 1'b1;
        end
        if (winner[EV_DTLB] || winner[EV_ITLB]) begin
          exception_start = 1'b1;
          mmu_strobe      = 1'b1;
        end
        if (winner[EV_IRQ]) begin
          irq_start              = 1'b1;
          exception_disable_irqs = 1'b1;
        end
        state_next = S_REDIRECT;
      end

      S_REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        if (winner[EV_ABORT]) begin
          redirect_pc = {vector_base, 6'h14};
        end else if (winner[EV_DTLB]) begin
          redirect_pc = {dtlb_miss_handler, 2'b00};
        end else if (winner[EV_ITLB]) begin
          redirect_pc = {itlb_miss_handler, 2'b00};
        end else if (winner[EV_ILLEGAL]) begin
          redirect_pc = {vector_base, 6'h04};
        end else if (winner[EV_IRQ]) begin
          redirect_pc = {vector_base, 6'h0c};
        end
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oldland_exception_ctrl.sv
// Testbench for oldland_exception_ctrl: directed scenarios with literal
// expectations, then randomized traffic. A sequence-level reference
// model is checked against the DUT on every cycle.
module tb_oldland_exception_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_abort_req, dtlb_miss_req, itlb_miss_req, illegal_instr_req;
  logic        irq_req, irqs_enabled, pipe_idle;
  logic [31:0] irq_resume_pc;
  logic [25:0] vector_base;
  logic [29:0] dtlb_miss_handler, itlb_miss_handler;
  logic        stall, pipeline_flush, exception_start, irq_start;
  logic        exception_disable_irqs, exception_disable_mmu;
  logic [31:0] exception_fault_address, redirect_pc;
  logic        redirect_valid, drain_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  oldland_exception_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .data_abort_req(data_abort_req), .dtlb_miss_req(dtlb_miss_req),
    .itlb_miss_req(itlb_miss_req), .illegal_instr_req(illegal_instr_req),
    .irq_req(irq_req), .irqs_enabled(irqs_enabled),
    .irq_resume_pc(irq_resume_pc), .pipe_idle(pipe_idle),
    .vector_base(vector_base), .dtlb_miss_handler(dtlb_miss_handler),
    .itlb_miss_handler(itlb_miss_handler),
    .stall(stall), .pipeline_flush(pipeline_flush),
    .exception_start(exception_start), .irq_start(irq_start),
    .exception_disable_irqs(exception_disable_irqs),
    .exception_disable_mmu(exception_disable_mmu),
    .exception_fault_address(exception_fault_address),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A sequence is tracked by its cycle index t (0 = first drain cycle) and
  // the index at which draining ended; ENTER and REDIRECT follow it.
  bit          m_valid = 0;
  bit [3:0]    m_pend  = 0;   // abort, dtlb, itlb, illegal
  bit          m_seq   = 0;
  int          m_t     = 0;
  int          m_exit  = -1;
  bit          m_sirq  = 0;
  logic [31:0] m_spc   = 0;
  logic [31:0] m_fa    = 0;
  int          m_sel   = 0;   // 0..3 as pending index, 4 = irq
  bit          m_dto   = 0;

  task automatic model_step();
    bit [3:0] pulses;
    bit [3:0] newp;
    if (!rst) begin
      m_valid = 1; m_pend = 0; m_seq = 0; m_t = 0; m_exit = -1;
      m_sirq = 0; m_spc = 0; m_fa = 0; m_sel = 0; m_dto = 0;
      return;
    end
    if (!m_valid) return;
`ifdef OLDLAND_TLB_MISS_EN
    pulses = {illegal_instr_req, itlb_miss_req, dtlb_miss_req, data_abort_req};
`else
    pulses = {illegal_instr_req, 1'b0, 1'b0, data_abort_req};
`endif
    newp = m_pend;
    if (m_seq && m_exit >= 0 && m_t == m_exit + 1 && m_sel < 4) newp[m_sel] = 1'b0;
    newp = newp | pulses;
    if (!m_seq) begin
      if (m_pend != 0 || (irq_req && irqs_enabled)) begin
        m_seq = 1; m_t = 0; m_exit = -1;
        m_sirq = irq_req && irqs_enabled;
        m_spc = irq_resume_pc;
      end
    end else if (m_exit < 0) begin
      if (pipe_idle || (m_t + 1 >= TO)) begin
        m_exit = m_t;
        if (!pipe_idle) m_dto = 1;
        m_sel = 4;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) m_sel = i;
        if (m_sel == 4 && m_sirq) m_fa = m_spc;
      end
      m_t++;
    end else if (m_t == m_exit + 1) begin
      m_t++;
    end else begin
      m_seq = 0;
    end
    m_pend = newp;
  endtask

  task automatic model_compare();
    bit dr, en, rd;
    logic [31:0] epc;
    dr  = m_seq && m_exit < 0;
    en  = m_seq && m_exit >= 0 && m_t == m_exit + 1;
    rd  = m_seq && m_exit >= 0 && m_t == m_exit + 2;
    epc = 32'h0;
    if (rd) begin
      case (m_sel)
        0: epc = {vector_base, 6'h14};
        1: epc = {dtlb_miss_handler, 2'b00};
        2: epc = {itlb_miss_handler, 2'b00};
        3: epc = {vector_base, 6'h04};
        default: epc = {vector_base, 6'h0c};
      endcase
    end
    chk("stall", stall, m_seq);
    chk("pipeline_flush", pipeline_flush, dr && m_t == 0);
    chk("exception_start", exception_start, en && m_sel != 4);
    chk("irq_start", irq_start, en && m_sel == 4);
    chk("disable_irqs", exception_disable_irqs, en && (m_sel == 0 || m_sel == 3 || m_sel == 4));
    chk("disable_mmu", exception_disable_mmu, en && (m_sel == 1 || m_sel == 2));
    chk("fault_address", exception_fault_address, m_fa);
    chk("redirect_valid", redirect_valid, rd);
    chk("redirect_pc", redirect_pc, epc);
    chk("drain_timeout", drain_timeout, m_dto);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_valid) model_compare();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_redirect(output int n, output bit prev_s, output bit prev_i, output bit prev_m);
    n = 0; prev_s = 0; prev_i = 0; prev_m = 0;
    while (!redirect_valid && n < 40) begin
      prev_s = exception_start;
      prev_i = exception_disable_irqs;
      prev_m = exception_disable_mmu;
      tick();
      n++;
    end
  endtask

  initial begin
    int n, sc;
    bit saw, ps, pi, pm;
    rst = 0; data_abort_req = 0; dtlb_miss_req = 0; itlb_miss_req = 0;
    illegal_instr_req = 0; irq_req = 0; irqs_enabled = 1; pipe_idle = 1;
    irq_resume_pc = 0; vector_base = 26'h100;
    dtlb_miss_handler = 30'h400; itlb_miss_handler = 30'h800;

    repeat (3) tick();
    chk("reset stall", stall, 0);
    chk("reset redirect_valid", redirect_valid, 0);
    chk("reset fault_address", exception_fault_address, 0);
    chk("reset drain_timeout", drain_timeout, 0);
    rst = 1;
    repeat (2) tick();

    // illegal instruction, minimum latency
    illegal_instr_req = 1; tick(); illegal_instr_req = 0;
    wait_redirect(n, ps, pi, pm);
    chk("illegal latency", n, 3);
    chk("illegal redirect_pc", redirect_pc, 32'h4004);
    chk("illegal start before redirect", ps, 1);
    chk("illegal disable_irqs before redirect", pi, 1);
    repeat (3) tick();

    // qualified interrupt
    irq_resume_pc = 32'h1230; irq_req = 1; irqs_enabled = 1;
    n = 0;
    while (!irq_start && n < 40) begin tick(); n++; end
    chk("irq_start seen", irq_start, 1);
    chk("irq fault_address", exception_fault_address, 32'h1230);
    irq_req = 0;
    wait_redirect(n, ps, pi, pm);
    chk("irq redirect_pc", redirect_pc, 32'h400c);
    repeat (3) tick();

    // interrupt masked
    irqs_enabled = 0; irq_req = 1; saw = 0;
    repeat (10) begin tick(); if (stall) saw = 1; end
    chk("masked irq no stall", saw, 0);
    irq_req = 0; irqs_enabled = 1;
    repeat (2) tick();

    // data abort and DTLB miss together
    data_abort_req = 1; dtlb_miss_req = 1; tick();
    data_abort_req = 0; dtlb_miss_req = 0;
    wait_redirect(n, ps, pi, pm);
    chk("abort redirect_pc", redirect_pc, 32'h4014);
    tick();
`ifdef OLDLAND_TLB_MISS_EN
    wait_redirect(n, ps, pi, pm);
    chk("dtlb redirect_pc", redirect_pc, 32'h1000);
    chk("dtlb disable_mmu before redirect", pm, 1);
`else
    saw = 0;
    repeat (10) begin tick(); if (stall) saw = 1; end
    chk("dtlb ignored no stall", saw, 0);
`endif
    repeat (3) tick();

    // drain timeout
    pipe_idle = 0;
    illegal_instr_req = 1; tick(); illegal_instr_req = 0;
    n = 0; sc = 0;
    while (!exception_start && n < 60) begin
      tick(); n++;
      if (stall && !exception_start) sc++;
    end
    chk("timeout drain cycles", sc, TO);
    chk("timeout flag set", drain_timeout, 1);
    pipe_idle = 1;
    repeat (10) tick();
    chk("timeout flag sticky", drain_timeout, 1);

    // reset in DRAIN
    pipe_idle = 0;
    data_abort_req = 1; tick(); data_abort_req = 0;
    n = 0;
    while (!stall && n < 20) begin tick(); n++; end
    chk("in drain before reset", stall, 1);
    rst = 0; tick();
    chk("reset in drain stall", stall, 0);
    chk("reset in drain timeout flag", drain_timeout, 0);
    rst = 1; pipe_idle = 1; saw = 0;
    repeat (8) begin tick(); if (stall || exception_start) saw = 1; end
    chk("reset cleared pending", saw, 0);

    // ITLB miss
    itlb_miss_req = 1; tick(); itlb_miss_req = 0;
`ifdef OLDLAND_TLB_MISS_EN
    wait_redirect(n, ps, pi, pm);
    chk("itlb redirect_pc", redirect_pc, 32'h2000);
`else
    saw = 0;
    repeat (10) begin tick(); if (stall || redirect_valid) saw = 1; end
    chk("itlb ignored", saw, 0);
`endif
    repeat (3) tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      data_abort_req    = ($urandom_range(0, 19) == 0);
      dtlb_miss_req     = ($urandom_range(0, 19) == 0);
      itlb_miss_req     = ($urandom_range(0, 19) == 0);
      illegal_instr_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) irq_req = ~irq_req;
      if ($urandom_range(0, 31) == 0) irqs_enabled = ~irqs_enabled;
      irq_resume_pc = $urandom;
      if ($urandom_range(0, 63) == 0) vector_base = 26'($urandom);
      if ($urandom_range(0, 63) == 0) dtlb_miss_handler = 30'($urandom);
      if ($urandom_range(0, 63) == 0) itlb_miss_handler = 30'($urandom);
      if (((c / 200) % 5) == 4) pipe_idle = ($urandom_range(0, 15) == 0);
      else pipe_idle = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst = 1; data_abort_req = 0; dtlb_miss_req = 0; itlb_miss_req = 0;
    illegal_instr_req = 0; irq_req = 0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
